// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port register file.
// Define RF_ARB_WRITE_PRIORITY_EN to let a write beat a read on a mixed-op tie.
`timescale 1ns/1ps
module regfile_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_write,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic [1:0]            req_ready,
  output logic [1:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [DATA_W-1:0]     rf_data_in,
  output logic [ADDR_W-1:0]     rf_write_addr,
  output logic [ADDR_W-1:0]     rf_read_addr,
  output logic                  rf_write_en,
  input  logic [DATA_W-1:0]     rf_data_out
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t              state, state_nxt;
  logic                grant;
  logic                accept;
  logic                last_grant;
  logic                op_write;
  logic                op_idx;
  logic [ADDR_W-1:0]   wr_addr_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;

  // Winner of this cycle; only meaningful while at least one request is valid.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    grant = req_valid[1];
    if (&req_valid) begin
`ifdef RF_ARB_WRITE_PRIORITY_EN
      if (req_write[0] != req_write[1])
        grant = req_write[1];
      else
        grant = ~last_grant;
`else
      grant = ~last_grant;
`endif
    end
  end

  assign accept    = (state == IDLE) && (|req_valid) && !reset;
  assign sel_addr  = grant ? req_addr[2*ADDR_W-1:ADDR_W]   : req_addr[ADDR_W-1:0];
  assign sel_wdata = grant ? req_wdata[2*DATA_W-1:DATA_W]  : req_wdata[DATA_W-1:0];

  // State register; the async reset kills an in-flight ISSUE immediately.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 2'b00;
    rsp_valid   = 2'b00;
    rsp_rdata   = '0;
    rf_write_en = 1'b0;
    if (state == IDLE && !reset && (|req_valid))
      req_ready[grant] = 1'b1;
    if (state == ISSUE) begin
      if (op_write) begin
        rf_write_en = 1'b1;
      end else begin
        rsp_valid[op_idx] = 1'b1;
        rsp_rdata         = rf_data_out;
      end
    end
  end

  // Captured request; write and read address registers are kept apart so each
  // register-file port holds its own last value between operations.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
      op_write   <= 1'b0;
      op_idx     <= 1'b0;
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      wdata_q    <= '0;
    end else if (accept) begin
      last_grant <= grant;
      op_write   <= req_write[grant];
      op_idx     <= grant;
      if (req_write[grant]) begin
        wr_addr_q <= sel_addr;
        wdata_q   <= sel_wdata;
      end else begin
        rd_addr_q <= sel_addr;
      end
    end
  end

  assign rf_write_addr = wr_addr_q;
  assign rf_data_in    = wdata_q;
  assign rf_read_addr  = rd_addr_q;

endmodule

// File: doc/regfile_arbiter.md
REGFILE_ARBITER -- requirements
Module: regfile_arbiter

Interface
REQ-001 Parameter: DATA_W, default 16, register data width.
REQ-002 Parameter: ADDR_W, default 3, register address width (8 registers).
REQ-003 Port: clk  input  1  single clock; all state on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: req_valid  input  2  per-requester request valid; bit i = requester i.
REQ-006 Port: req_write  input  2  per-requester op; 1 = write, 0 = read.
REQ-007 Port: req_addr  input  2*ADDR_W  per-requester register address; slice i = requester i.
REQ-008 Port: req_wdata  input  2*DATA_W  per-requester write data.
REQ-009 Port: req_ready  output  2  request accepted this cycle when valid and ready both high.
REQ-010 Port: rsp_valid  output  2  one-cycle read-response pulse per requester.
REQ-011 Port: rsp_rdata  output  DATA_W  read data, valid when any rsp_valid bit high.
REQ-012 Port: rf_data_in  output  DATA_W  register-file write data.
REQ-013 Port: rf_write_addr  output  ADDR_W  register-file write address.
REQ-014 Port: rf_read_addr  output  ADDR_W  register-file read address.
REQ-015 Port: rf_write_en  output  1  register-file write enable.
REQ-016 Port: rf_data_out  input  DATA_W  register-file combinational read data.

Function
REQ-017 The block SHALL implement FSM states IDLE and ISSUE; IDLE -> ISSUE on any accept, ISSUE -> IDLE unconditionally.
REQ-018 In IDLE, req_ready SHALL be high for exactly the granted requester and only if its req_valid is high; in ISSUE, req_ready SHALL be 2'b00.
REQ-019 Arbitration SHALL be round-robin: with both valid, grant the requester not granted most recently; with one valid, grant it.
REQ-020 The last-grant pointer SHALL update only on accept.
REQ-021 On accept, op, address, wdata and requester index SHALL be registered; rf_* outputs SHALL be driven from these registers during ISSUE only.
REQ-022 Write: rf_write_en SHALL be high for exactly the ISSUE cycle, with rf_write_addr and rf_data_in from the accepted request; rsp_valid stays low.
REQ-023 Read: rf_write_en SHALL be low; rf_read_addr SHALL hold the accepted address during ISSUE; rsp_valid[i] SHALL pulse in that ISSUE cycle with rsp_rdata = rf_data_out.
REQ-024 Latency: accept in cycle N -> register-file access and read response in cycle N+1; peak throughput one operation per 2 cycles.
REQ-025 Outside ISSUE, rf_write_en SHALL be 0, rsp_valid 2'b00, rf_* addresses/data hold last values, rsp_rdata = 0.
REQ-026 Requests not accepted SHALL not be dropped; requester holds valid and payload until ready.
REQ-027 A write and a read from different requesters SHALL never reach the register file in the same cycle.

Reset
REQ-028 Reset SHALL asynchronously force state IDLE, last-grant pointer = requester 1 (so requester 0 wins first tie), all registered fields 0.
REQ-029 Reset asserted during ISSUE SHALL immediately drop rf_write_en and rsp_valid; the in-flight operation is abandoned, no response issued.
REQ-030 During reset, req_ready SHALL be 2'b00.

Configuration
REQ-031 Macro RF_ARB_WRITE_PRIORITY_EN defined: when both valid with different ops, the write SHALL win regardless of pointer; pointer still updates to the winner; same-op ties use round-robin.
REQ-032 Macro RF_ARB_WRITE_PRIORITY_EN undefined: pure round-robin per REQ-019.

Verification
REQ-033 Reset, req0 write addr 3 data 16'hBEEF -> ready[0] cycle 1, rf_write_en=1, rf_write_addr=3, rf_data_in=16'hBEEF in cycle 2.
REQ-034 req1 read addr 3, rf_data_out=16'hBEEF -> rsp_valid=2'b10, rsp_rdata=16'hBEEF one cycle after accept, rf_write_en=0.
REQ-035 Both valid (reads) continuously after reset -> grants alternate 0,1,0,1 every 2 cycles; no requester starved.
REQ-036 Reset asserted mid-ISSUE of a write -> rf_write_en falls without clock edge; after release, first tie grants requester 0.
REQ-037 Macro defined: req0 read, req1 write simultaneously after reset -> req1 accepted first; macro undefined -> req0 accepted first.
REQ-038 req_valid held through ISSUE -> req_ready stays 0 in ISSUE, accepted next IDLE cycle, payload unchanged.
